// File: rtl/conv_frame_sched.sv
// Frame scheduler for the 8x8 -> 6x6 convolution engine: streams source frames through the engine
// and writes each frame's 36 results to destination RAM; a timeout on the engine ends the job with error.
module conv_frame_sched #(
  parameter int IN_PIX  = 64,
  parameter int OUT_PIX = 36,
  parameter int ADDR_W  = 12,
  parameter int FRM_W   = 8,
  parameter int TIMEOUT = 255,
  parameter int FLUSH   = 160
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [FRM_W-1:0]  num_frames,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              conv_in_st,
  output logic [7:0]        conv_din,
  input  logic              conv_out_st,
  input  logic [15:0]       conv_dout,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data
);
  localparam int CNT_W = $clog2(FLUSH + TIMEOUT + IN_PIX + OUT_PIX);

  typedef enum logic [2:0] {S_FLUSH, S_IDLE, S_LOAD, S_WAIT, S_DRAIN, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FRM_W-1:0]  frm_q, frm_d;
  logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
  logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              rd_vld_q, rd_vld_d;
  logic [7:0]        din_q, din_d;

  // Read strobes come straight from the load counter; RAM data is forwarded the cycle it returns.
  assign rd_en      = (state_q == S_LOAD) && (cnt_q < CNT_W'(IN_PIX));
  assign rd_addr    = rd_en ? (src_ptr_q + ADDR_W'(cnt_q)) : '0;
  assign conv_in_st = (state_q == S_LOAD) && (cnt_q == '0);
  assign conv_din   = rd_vld_q ? rd_data : din_q;
  assign busy       = (state_q == S_LOAD) || (state_q == S_WAIT) ||
                      (state_q == S_DRAIN) || (state_q == S_GAP);
  assign done       = done_q;
  assign error      = error_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    frm_d     = frm_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    done_d    = 1'b0;
    error_d   = error_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_vld_d  = rd_en;
    din_d     = conv_din;

    case (state_q)
      S_FLUSH: begin
        if (cnt_q == CNT_W'(FLUSH - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_IDLE: begin
        if (start) begin
          error_d = 1'b0;
          if (num_frames == '0) begin
            done_d = 1'b1;
          end else begin
            frm_d     = num_frames;
            src_ptr_d = src_base;
            dst_ptr_d = dst_base;
            cnt_d     = '0;
            state_d   = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (cnt_q == CNT_W'(IN_PIX)) begin
          state_d   = S_WAIT;
          cnt_d     = '0;
          src_ptr_d = src_ptr_q + ADDR_W'(IN_PIX);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (conv_out_st) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          error_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        wr_en_d   = 1'b1;
        wr_data_d = conv_dout;
        wr_addr_d = dst_ptr_q + ADDR_W'(cnt_q);
        if (cnt_q == CNT_W'(OUT_PIX - 1)) begin
          state_d   = S_GAP;
          cnt_d     = '0;
          dst_ptr_d = dst_ptr_q + ADDR_W'(OUT_PIX);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        // Two quiet cycles let the engine's output counter wrap before the next load.
        if (cnt_q == CNT_W'(1)) begin
          cnt_d = '0;
          if (frm_q == FRM_W'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            frm_d   = frm_q - FRM_W'(1);
            state_d = S_LOAD;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_FLUSH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FLUSH;
      cnt_q     <= '0;
      frm_q     <= '0;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_vld_q  <= 1'b0;
      din_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      frm_q     <= frm_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      done_q    <= done_d;
      error_q   <= error_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_vld_q  <= rd_vld_d;
      din_q     <= din_d;
    end
  end
endmodule
